dht11_reader: RTL and testbench
===============================

// Module: dht11_reader
// PURPOSE
//  Single-wire DHT11 master. On a start request it drives the start pulse, checks the
//  sensor response and captures 40 data bits MSB first. It then verifies the checksum
//  and presents humidity/temperature bytes. Sits upstream of uart_tx and supplies the
//  16-bit word that goes back to the PC. The top level owns the tristate:
//  dht_data = dht_oe ? 1'b0 : 1'bz; dht_in = dht_data.
// PARAMETERS
//  CLK_FREQ_HZ    50_000_000  system clock; 1 us = CLK_FREQ_HZ/1_000_000 cycles (integer)
//  START_LOW_US   19000       host low pulse length
//  TIMEOUT_US     200         max wait for any expected edge
//  BIT_THRESH_US  50          high pulse > threshold -> 1, else 0
//  MIN_PERIOD_MS  1000        cooldown from end of a transaction to next accepted start
// PORTS
//  clock      in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-high
//  start      in   1  1-cycle request; ignored unless state==IDLE
//  dht_in     in   1  raw line level (asynchronous)
//  dht_oe     out  1  1 = pull line low, 0 = release (pull-up)
//  busy       out  1  high in every state except IDLE
//  done       out  1  1-cycle pulse, good frame captured
//  error      out  1  1-cycle pulse, transaction failed
//  error_code out  2  00 none, 01 no response, 10 bit timeout, 11 checksum; held until next start
//  hum_int    out  8  humidity integer byte
//  hum_dec    out  8  humidity decimal byte
//  temp_int   out  8  temperature integer byte
//  temp_dec   out  8  temperature decimal byte
// BEHAVIOUR
//  Reset: state=IDLE, dht_oe=0, busy=0, done=0, error=0, error_code=00, all data bytes 0.
//  Reset mid-transaction releases the line on the next edge; no done/error pulse is issued.
//  dht_in passes through a 2-FF synchronizer. All edge detection uses the synced value.
//  Edge latency: 2-3 cycles, identical on both edges, so pulse widths are unbiased.
//  One shared us-tick counter and one 32-bit cycle counter. The cycle counter clears on every state entry.
//  States:
//   IDLE      start=1 -> START_LOW; error_code<=00, shift reg and bit count cleared
//   START_LOW dht_oe=1 for START_LOW_US, then dht_oe=0 -> WAIT_RESP
//   WAIT_RESP falling edge -> RESP_LOW; timeout -> FAIL(01)
//   RESP_LOW  rising edge -> RESP_HIGH; timeout -> FAIL(01)
//   RESP_HIGH falling edge -> BIT_LOW; timeout -> FAIL(01)
//   BIT_LOW   rising edge -> BIT_HIGH; timeout -> FAIL(10)
//   BIT_HIGH  falling edge: shift in (width > BIT_THRESH_US); count==39 -> CHECK
//             else BIT_LOW; timeout -> FAIL(10)
//   CHECK     sum = (b0+b1+b2+b3) mod 256; equal to b4 -> load outputs, done=1
//             -> COOLDOWN; mismatch -> FAIL(11)
//   FAIL      error=1 and error_code set for 1 cycle -> COOLDOWN
//   COOLDOWN  wait MIN_PERIOD_MS, counted from entry -> IDLE; start here is dropped
//  Byte order on the wire: b0=hum_int, b1=hum_dec, b2=temp_int, b3=temp_dec, b4=checksum.
//  The data outputs change only in the CHECK success cycle. On failure they keep their old values.
//  A width exactly equal to the threshold decodes as 0.
//  A timeout fires when the counter reaches TIMEOUT_US with no edge.
//  done and error are never asserted in the same cycle.
//  start coincident with reset: reset wins.
// TESTING (CLK_FREQ_HZ=1_000_000, START_LOW_US=100, MIN_PERIOD_MS=1)
//  1 sensor model sends 80/80 response, then 0x37,0x00,0x19,0x00,0x50 (0:27us, 1:70us high)
//    -> dht_oe low exactly 100 cycles; done pulse; hum_int=55, temp_int=25; error_code=00
//  2 same frame with checksum 0x51 -> error pulse, error_code=11, data bytes unchanged from test 1
//  3 line never pulled low after release -> error pulse 200+-3 cycles after release, code 01
//  4 sensor stops after bit 20 (line stays high) -> error, code 10; busy through cooldown
//  5 start pulses during START_LOW, BIT_HIGH and COOLDOWN -> all ignored, no second transaction
//  6 reset asserted during bit 10 -> dht_oe=0, busy=0 the next cycle; fresh start then succeeds
//  Checks: bytes summing >255 (e.g. 0xFF,0x01,0x02,0x00 / 0x02) pass; 50us high decodes as 0

Source files
------------

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: issues the start pulse, validates the sensor response,
// captures 40 bits MSB first and verifies the checksum before publishing the bytes.
module dht11_reader #(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int START_LOW_US  = 19000,
   parameter int TIMEOUT_US    = 200,
   parameter int BIT_THRESH_US = 50,
   parameter int MIN_PERIOD_MS = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] error_code,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec
);
   localparam int          CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
   localparam int          TW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam logic [31:0] COOL_US    = 32'(MIN_PERIOD_MS) * 32'd1000;

   typedef enum logic [3:0] {
      IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH,
      BIT_LOW, BIT_HIGH, CHECK, FAIL, COOLDOWN
   } state_t;

   state_t state, state_next;

   // sync[1:0] is the synchronizer, sync[2] the previous synced level; both
   // edges see the same pipeline so measured pulse widths carry no bias.
   logic [2:0] sync;
   logic       rose, fell;

   always_ff @(posedge clock) begin
      if (reset) sync <= 3'b111;
      else       sync <= {sync[1:0], dht_in};
   end

   assign rose = sync[1] & ~sync[2];
   assign fell = ~sync[1] & sync[2];

   logic [TW-1:0] tick_cnt;
   logic [31:0]   us_cnt;
   logic          tick;
   logic [31:0]   width;
   logic          start_done, tmo, cool_done, bit_val;

   assign tick = (tick_cnt == TW'(CYC_PER_US - 1));

   // Both counters restart on every state change, so us_cnt is time spent in the state.
   always_ff @(posedge clock) begin
      if (reset || state_next != state || state == IDLE) begin
         tick_cnt <= '0;
         us_cnt   <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) us_cnt <= us_cnt + 32'd1;
      end
   end

   assign start_done = tick && (us_cnt == 32'(START_LOW_US - 1));
   assign tmo        = tick && (us_cnt == 32'(TIMEOUT_US - 1));
   assign cool_done  = tick && (us_cnt == COOL_US - 32'd1);
   assign width      = us_cnt + {31'd0, tick};
   assign bit_val    = (width > 32'(BIT_THRESH_US));

   logic [39:0] sr;
   logic [5:0]  bit_cnt;
   logic [7:0]  sum;
   logic        sum_ok;
   logic [1:0]  fail_code;

   assign sum    = sr[39:32] + sr[31:24] + sr[23:16] + sr[15:8];
   assign sum_ok = (sum == sr[7:0]);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      fail_code  = 2'b00;
      dht_oe     = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE:      if (start) state_next = START_LOW;
         START_LOW: begin
            dht_oe = 1'b1;
            if (start_done) state_next = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (fell)     state_next = RESP_LOW;
            else if (tmo) begin state_next = FAIL; fail_code = 2'b01; end
         end
         RESP_LOW: begin
            if (rose)     state_next = RESP_HIGH;
            else if (tmo) begin state_next = FAIL; fail_code = 2'b01; end
         end
         RESP_HIGH: begin
            if (fell)     state_next = BIT_LOW;
            else if (tmo) begin state_next = FAIL; fail_code = 2'b01; end
         end
         BIT_LOW: begin
            if (rose)     state_next = BIT_HIGH;
            else if (tmo) begin state_next = FAIL; fail_code = 2'b10; end
         end
         BIT_HIGH: begin
            if (fell)     state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
            else if (tmo) begin state_next = FAIL; fail_code = 2'b10; end
         end
         CHECK: begin
            if (sum_ok) begin
               done       = ~reset;
               state_next = COOLDOWN;
            end else begin
               state_next = FAIL;
               fail_code  = 2'b11;
            end
         end
         FAIL: begin
            error      = ~reset;
            state_next = COOLDOWN;
         end
         COOLDOWN:  if (cool_done) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         sr         <= '0;
         bit_cnt    <= '0;
         error_code <= 2'b00;
         hum_int    <= '0;
         hum_dec    <= '0;
         temp_int   <= '0;
         temp_dec   <= '0;
      end else begin
         if (state == IDLE && start) begin
            sr         <= '0;
            bit_cnt    <= '0;
            error_code <= 2'b00;
         end
         if (state == BIT_HIGH && fell) begin
            sr      <= {sr[38:0], bit_val};
            bit_cnt <= bit_cnt + 6'd1;
         end
         // Code lands on FAIL entry so it is already valid alongside the error pulse.
         if (state_next == FAIL) error_code <= fail_code;
         if (state == CHECK && sum_ok) begin
            hum_int  <= sr[39:32];
            hum_dec  <= sr[31:24];
            temp_int <= sr[23:16];
            temp_dec <= sr[15:8];
         end
      end
   end
endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader: a behavioural sensor drives the shared line
// while immediate assertions compare outputs against hand-computed values.
module tb_dht11_reader;
   logic       clock = 1'b0;
   logic       reset, start, sensor_low;
   logic       dht_in, dht_oe, busy, done, error;
   logic [1:0] error_code;
   logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

   int vectors = 0, miscompares = 0;

   // Open-drain line with pull-up: low if either side pulls.
   assign dht_in = ~(dht_oe | sensor_low);

   always #5 clock = ~clock;

   dht11_reader #(
      .CLK_FREQ_HZ(1_000_000), .START_LOW_US(100), .TIMEOUT_US(200),
      .BIT_THRESH_US(50), .MIN_PERIOD_MS(1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .dht_in(dht_in),
      .dht_oe(dht_oe), .busy(busy), .done(done), .error(error),
      .error_code(error_code), .hum_int(hum_int), .hum_dec(hum_dec),
      .temp_int(temp_int), .temp_dec(temp_dec)
   );

   int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int   oe_cycles = 0, oe_rises = 0, rel_cyc = 0, err_cyc = 0;
   logic oe_q = 1'b0;

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (error) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
      if (done && error) both_cnt <= both_cnt + 1;
      if (dht_oe) oe_cycles <= oe_cycles + 1;
      if (dht_oe && !oe_q) oe_rises <= oe_rises + 1;
      if (!dht_oe && oe_q) rel_cyc <= cyc;
      oe_q <= dht_oe;
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin step(1); n++; end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   // Pulses start, optionally injects a stray start mid START_LOW, returns on release.
   task automatic do_start(input bit stray);
      int n = 0;
      start = 1'b1; step(1); start = 1'b0;
      while (!dht_oe && n < 10) begin step(1); n++; end
      n = 0;
      while (dht_oe && n < 300) begin
         if (stray && n == 10) begin start = 1'b1; step(1); start = 1'b0; end
         else step(1);
         n++;
      end
      chk("line released", {31'd0, dht_oe}, 32'd0);
   endtask

   // Sensor: 80/80 response then nbits data bits (50 low + hi0/hi1 high).
   task automatic send(input logic [39:0] frame, input int nbits, input int hi0,
                       input int hi1, input int stray_bit, input int reset_bit);
      int hi;
      step(20);
      sensor_low = 1'b1; step(80);
      sensor_low = 1'b0; step(80);
      for (int i = 0; i < nbits; i++) begin
         sensor_low = 1'b1;
         if (i == reset_bit) begin
            step(10);
            reset = 1'b1; step(1);
            chk("reset mid oe", {31'd0, dht_oe}, 32'd0);
            chk("reset mid busy", {31'd0, busy}, 32'd0);
            reset = 1'b0; sensor_low = 1'b0;
            return;
         end
         step(50);
         sensor_low = 1'b0;
         hi = frame[39-i] ? hi1 : hi0;
         if (i == stray_bit) begin
            step(5); start = 1'b1; step(1); start = 1'b0; step(hi - 6);
         end else step(hi);
      end
      sensor_low = 1'b1; step(50);
      sensor_low = 1'b0;
   endtask

   initial begin
      int d0, e0, r0, o0, lat;
      reset = 1'b1; start = 1'b0; sensor_low = 1'b0;
      step(3);
      chk("rst oe", {31'd0, dht_oe}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst error", {31'd0, error}, 32'd0);
      chk("rst code", {30'd0, error_code}, 32'd0);
      chk("rst bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'd0);
      start = 1'b1; step(1);
      reset = 1'b0; start = 1'b0; step(1);
      chk("start under reset", {31'd0, busy}, 32'd0);

      // 1: good frame 55.0 %, 25.0 C
      d0 = done_cnt; e0 = err_cnt; o0 = oe_cycles;
      do_start(1'b0);
      chk("t1 oe width", oe_cycles - o0, 32'd100);
      send(40'h37_00_19_00_50, 40, 27, 70, -1, -1);
      chk("t1 done", done_cnt - d0, 32'd1);
      chk("t1 no err", err_cnt - e0, 32'd0);
      chk("t1 bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37_00_19_00);
      chk("t1 code", {30'd0, error_code}, 32'd0);
      chk("t1 busy cooldown", {31'd0, busy}, 32'd1);
      wait_idle("t1 idle");

      // 2: checksum mismatch
      d0 = done_cnt; e0 = err_cnt;
      do_start(1'b0);
      send(40'h37_00_19_00_51, 40, 27, 70, -1, -1);
      step(2);
      chk("t2 err", err_cnt - e0, 32'd1);
      chk("t2 no done", done_cnt - d0, 32'd0);
      chk("t2 code", {30'd0, error_code}, 32'd3);
      chk("t2 bytes kept", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37_00_19_00);
      wait_idle("t2 idle");

      // 3: no response
      e0 = err_cnt;
      do_start(1'b0);
      step(260);
      lat = err_cyc - rel_cyc;
      chk("t3 err", err_cnt - e0, 32'd1);
      chk("t3 code", {30'd0, error_code}, 32'd1);
      chk($sformatf("t3 latency %0d in 197..203", lat), {31'd0, (lat >= 197 && lat <= 203)}, 32'd1);
      wait_idle("t3 idle");

      // 4: sensor stalls high after bit 20; bytes from the partial frame must not load
      e0 = err_cnt; d0 = done_cnt;
      do_start(1'b0);
      send(40'h40_01_1A_02_5D, 20, 27, 70, -1, -1);
      step(210);
      chk("t4 err", err_cnt - e0, 32'd1);
      chk("t4 code", {30'd0, error_code}, 32'd2);
      chk("t4 bytes kept", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37_00_19_00);
      step(500);
      chk("t4 busy cooldown", {31'd0, busy}, 32'd1);
      wait_idle("t4 idle");

      // 5: stray starts in START_LOW, BIT_HIGH and COOLDOWN
      r0 = oe_rises; d0 = done_cnt;
      do_start(1'b1);
      send(40'h37_00_19_00_50, 40, 27, 70, 5, -1);
      step(100); start = 1'b1; step(1); start = 1'b0;
      wait_idle("t5 idle");
      step(20);
      chk("t5 one txn", oe_rises - r0, 32'd1);
      chk("t5 done", done_cnt - d0, 32'd1);
      chk("t5 still idle", {31'd0, busy}, 32'd0);

      // 6: reset during bit 10, then a wrapping-checksum frame with 50us zeros
      d0 = done_cnt; e0 = err_cnt;
      do_start(1'b0);
      send(40'h37_00_19_00_50, 40, 27, 70, -1, 10);
      step(5);
      chk("t6 no pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
      chk("t6 bytes reset", {hum_int, hum_dec, temp_int, temp_dec}, 32'd0);
      do_start(1'b0);
      send(40'hFF_01_02_00_02, 40, 50, 51, -1, -1);
      chk("t6 done", done_cnt - d0, 32'd1);
      chk("t6 bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'hFF_01_02_00);
      chk("t6 code", {30'd0, error_code}, 32'd0);
      wait_idle("t6 idle");

      chk("done&error overlap", both_cnt, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
